// File: rtl/mux_nto1_pipe.sv
// N_CH-to-1 channel selector with valid/ready handshake and one registered output stage.
// Define MUX_RR_EN to add round-robin arbitration (mode=1); otherwise the block is direct-select only.
module mux_nto1_pipe #(
  parameter  int N_CH  = 8,
  parameter  int WIDTH = 8,
  localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_out_valid;

  logic             w_load;
  logic             w_dir_vld;
  logic [SEL_W-1:0] w_dir_idx;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant_idx;
  logic [WIDTH-1:0] w_word;

  // Gated by rst_n so no channel sees in_ready while the block is held in reset.
  assign w_load = rst_n & (~r_out_valid | out_ready);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_dir_vld = 1'b0;
    w_dir_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) begin
        w_dir_vld = 1'b1;
        w_dir_idx = SEL_W'(i);
      end
    end
  end

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] r_rr_ptr;
  logic [N_CH-1:0]  w_rot;
  logic             w_rr_vld;
  logic [SEL_W-1:0] w_rr_idx;

  // w_rot[k] is the valid bit of channel (rr_ptr + k) mod N_CH.
  assign w_rot = N_CH'({in_valid, in_valid} >> r_rr_ptr);

  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    // Scan from the far end so the lowest offset from rr_ptr is written last and wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = (int'(r_rr_ptr) + k >= N_CH) ? SEL_W'(int'(r_rr_ptr) + k - N_CH)
                                                : SEL_W'(int'(r_rr_ptr) + k);
      end
    end
  end

  assign w_grant_vld = mode ? w_rr_vld : w_dir_vld;
  assign w_grant_idx = mode ? w_rr_idx : w_dir_idx;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (mode && w_load && w_grant_vld) begin
      r_rr_ptr <= (w_grant_idx == SEL_W'(N_CH - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_grant_vld   = w_dir_vld;
  assign w_grant_idx   = w_dir_idx;
`endif

  always_comb begin
    w_word   = '0;
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant_idx == SEL_W'(i)) begin
        w_word      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_load & w_grant_vld;
      end
    end
  end

  // NOTE: the data/channel flops are cleared by reset too, so outputs are defined from time zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_load) begin
      r_out_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_out_data <= w_word;
        r_out_chan <= w_grant_idx;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: an 8-channel instance (a_*) and a 5-channel instance (b_*).
// Round-robin expectations switch on MUX_RR_EN, matching the build of the design.
module tb_mux_nto1_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] a_in_data;
  logic [7:0]  a_in_valid, a_in_ready;
  logic [2:0]  a_sel, a_out_chan;
  logic        a_mode, a_out_valid, a_out_ready;
  logic [7:0]  a_out_data;

  logic [39:0] b_in_data;
  logic [4:0]  b_in_valid, b_in_ready;
  logic [2:0]  b_sel, b_out_chan;
  logic        b_mode, b_out_valid, b_out_ready;
  logic [7:0]  b_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  mux_nto1_pipe #(.N_CH(8), .WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .mode(a_mode), .out_data(a_out_data),
    .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  mux_nto1_pipe #(.N_CH(5), .WIDTH(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_in_data = {8'h77, 8'h66, 8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    b_in_data = {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0};
    a_in_valid = 8'hFF; b_in_valid = 5'h1F;
    a_sel = 3'd1; b_sel = 3'd1; a_mode = 1'b0; b_mode = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    #12;
    n_tests++; if (a_in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_a_in_ready: got %h expected 00", a_in_ready); end
    n_tests++; if (b_in_ready !== 5'h00) begin n_fail++; $display("FAIL reset_b_in_ready: got %h expected 00", b_in_ready); end
    n_tests++; if ({a_out_valid, a_out_data, a_out_chan} !== 12'h000) begin n_fail++; $display("FAIL reset_a_out: got v=%b d=%h c=%0d expected all zero", a_out_valid, a_out_data, a_out_chan); end
    n_tests++; if ({b_out_valid, b_out_data, b_out_chan} !== 12'h000) begin n_fail++; $display("FAIL reset_b_out: got v=%b d=%h c=%0d expected all zero", b_out_valid, b_out_data, b_out_chan); end
    @(negedge clk);
    rst_n = 1'b1;
    a_in_valid = 8'h00; b_in_valid = 5'h00;
    tick;
  endtask

  task automatic test_direct;
    a_sel = 3'd5; a_in_valid = 8'h20;
    #1;
    n_tests++; if (a_in_ready !== 8'h20) begin n_fail++; $display("FAIL direct_in_ready: got %h expected 20", a_in_ready); end
    tick;
    a_in_valid = 8'h00;
    n_tests++; if ({a_out_valid, a_out_data, a_out_chan} !== {1'b1, 8'hA5, 3'd5}) begin n_fail++; $display("FAIL direct_out: got v=%b d=%h c=%0d expected v=1 d=a5 c=5", a_out_valid, a_out_data, a_out_chan); end
    #1;
    n_tests++; if (a_in_ready !== 8'h00) begin n_fail++; $display("FAIL direct_idle_in_ready: got %h expected 00", a_in_ready); end
    tick;
    n_tests++; if ({a_out_valid, a_out_data, a_out_chan} !== {1'b0, 8'hA5, 3'd5}) begin n_fail++; $display("FAIL direct_drain: got v=%b d=%h c=%0d expected v=0 d=a5 c=5", a_out_valid, a_out_data, a_out_chan); end
  endtask

  task automatic test_back_to_back;
    a_sel = 3'd1; a_in_valid = 8'h02;
    tick;
    n_tests++; if ({a_out_valid, a_out_data, a_out_chan} !== {1'b1, 8'h11, 3'd1}) begin n_fail++; $display("FAIL b2b_first: got v=%b d=%h c=%0d expected v=1 d=11 c=1", a_out_valid, a_out_data, a_out_chan); end
    a_sel = 3'd2; a_in_valid = 8'h04;
    tick;
    n_tests++; if ({a_out_valid, a_out_data, a_out_chan} !== {1'b1, 8'h22, 3'd2}) begin n_fail++; $display("FAIL b2b_second: got v=%b d=%h c=%0d expected v=1 d=22 c=2", a_out_valid, a_out_data, a_out_chan); end
    a_in_valid = 8'h00;
    tick;
  endtask

  task automatic test_stall;
    a_sel = 3'd3; a_in_valid = 8'h08;
    tick;
    n_tests++; if ({a_out_valid, a_out_data, a_out_chan} !== {1'b1, 8'h33, 3'd3}) begin n_fail++; $display("FAIL stall_load: got v=%b d=%h c=%0d expected v=1 d=33 c=3", a_out_valid, a_out_data, a_out_chan); end
    a_out_ready = 1'b0; a_sel = 3'd6; a_in_valid = 8'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (a_in_ready !== 8'h00) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %h expected 00", i, a_in_ready); end
      tick;
      n_tests++; if ({a_out_valid, a_out_data, a_out_chan} !== {1'b1, 8'h33, 3'd3}) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b d=%h c=%0d expected v=1 d=33 c=3", i, a_out_valid, a_out_data, a_out_chan); end
    end
    a_out_ready = 1'b1;
    #1;
    n_tests++; if (a_in_ready !== 8'h40) begin n_fail++; $display("FAIL stall_release_in_ready: got %h expected 40", a_in_ready); end
    tick;
    a_in_valid = 8'h00;
    n_tests++; if ({a_out_valid, a_out_data, a_out_chan} !== {1'b1, 8'h66, 3'd6}) begin n_fail++; $display("FAIL stall_release_out: got v=%b d=%h c=%0d expected v=1 d=66 c=6", a_out_valid, a_out_data, a_out_chan); end
    tick;
  endtask

  task automatic test_reset_mid;
    a_sel = 3'd7; a_in_valid = 8'h80;
    tick;
    n_tests++; if ({a_out_valid, a_out_data} !== {1'b1, 8'h77}) begin n_fail++; $display("FAIL midrst_pre: got v=%b d=%h expected v=1 d=77", a_out_valid, a_out_data); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({a_out_valid, a_out_data, a_out_chan} !== 12'h000) begin n_fail++; $display("FAIL midrst_out: got v=%b d=%h c=%0d expected all zero", a_out_valid, a_out_data, a_out_chan); end
    n_tests++; if (a_in_ready !== 8'h00) begin n_fail++; $display("FAIL midrst_in_ready: got %h expected 00", a_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    a_in_valid = 8'h00;
    tick;
  endtask

  task automatic test_out_of_range;
    b_sel = 3'd2; b_in_valid = 5'h1F;
    tick;
    n_tests++; if ({b_out_valid, b_out_data, b_out_chan} !== {1'b1, 8'hC2, 3'd2}) begin n_fail++; $display("FAIL oor_load: got v=%b d=%h c=%0d expected v=1 d=c2 c=2", b_out_valid, b_out_data, b_out_chan); end
    b_sel = 3'd6;
    #1;
    n_tests++; if (b_in_ready !== 5'h00) begin n_fail++; $display("FAIL oor_sel6_in_ready: got %h expected 00", b_in_ready); end
    tick;
    n_tests++; if ({b_out_valid, b_out_data, b_out_chan} !== {1'b0, 8'hC2, 3'd2}) begin n_fail++; $display("FAIL oor_drain: got v=%b d=%h c=%0d expected v=0 d=c2 c=2", b_out_valid, b_out_data, b_out_chan); end
    b_sel = 3'd5;
    #1;
    n_tests++; if (b_in_ready !== 5'h00) begin n_fail++; $display("FAIL oor_sel5_in_ready: got %h expected 00", b_in_ready); end
    b_sel = 3'd4;
    #1;
    n_tests++; if (b_in_ready !== 5'h10) begin n_fail++; $display("FAIL oor_sel4_in_ready: got %h expected 10", b_in_ready); end
    tick;
    b_in_valid = 5'h00;
    n_tests++; if ({b_out_valid, b_out_data, b_out_chan} !== {1'b1, 8'hC4, 3'd4}) begin n_fail++; $display("FAIL oor_last_chan: got v=%b d=%h c=%0d expected v=1 d=c4 c=4", b_out_valid, b_out_data, b_out_chan); end
    tick;
  endtask

  task automatic test_mode;
    int exp1 [6];
    int exp2 [4];
`ifdef MUX_RR_EN
    exp1 = '{0, 1, 2, 3, 4, 0};
    exp2 = '{1, 4, 1, 4};
`else
    exp1 = '{2, 2, 2, 2, 2, 2};
    exp2 = '{1, 1, 1, 1};
`endif
    b_mode = 1'b1; b_sel = 3'd2; b_in_valid = 5'h1F;
    for (int i = 0; i < 6; i++) begin
      tick;
      n_tests++; if ({b_out_valid, b_out_chan} !== {1'b1, 3'(exp1[i])}) begin n_fail++; $display("FAIL mode_all[%0d]: got v=%b c=%0d expected v=1 c=%0d", i, b_out_valid, b_out_chan, exp1[i]); end
    end
    b_sel = 3'd1; b_in_valid = 5'b10010;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_tests++; if ({b_out_valid, b_out_data, b_out_chan} !== {1'b1, 8'hC0 + 8'(exp2[i]), 3'(exp2[i])}) begin n_fail++; $display("FAIL mode_sparse[%0d]: got v=%b d=%h c=%0d expected v=1 c=%0d", i, b_out_valid, b_out_data, b_out_chan, exp2[i]); end
    end
    b_mode = 1'b0; b_sel = 3'd2; b_in_valid = 5'h1F;
    tick;
    n_tests++; if ({b_out_valid, b_out_chan} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL mode_back_direct: got v=%b c=%0d expected v=1 c=2", b_out_valid, b_out_chan); end
    b_in_valid = 5'h00;
    tick;
  endtask

  initial begin
    test_reset;
    test_direct;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    test_out_of_range;
    test_mode;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
